// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the async-FIFO read-domain controllers.
// Holds the FSM state encoding, the id width and the round-robin search.
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int ID_W    = 3;
    localparam int MAX_REQ = 8;

    // One-hot of the first set request bit at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_search(
        input logic [MAX_REQ-1:0] req,
        input logic [ID_W-1:0]    ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] win;
        logic               found;
        int                 idx;
        logic [ID_W-1:0]    idx_b;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            idx   = (int'(ptr) + i) % n;
            idx_b = idx[ID_W-1:0];
            if (!found && (i < n) && req[idx_b]) begin
                win[idx_b] = 1'b1;
                found      = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module rr_priority_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] request,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic               any_req
);

    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] win_pad;
    logic               unused_win;

    always_comb begin
        req_pad                = '0;
        req_pad[NUM_REQ-1:0]   = request;
        win_pad                = rr_search(req_pad, rr_ptr, NUM_REQ);
    end

    assign winner     = win_pad[NUM_REQ-1:0];
    assign any_req    = |request;
    assign unused_win = ^win_pad;

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares the FIFO read port among NUM_REQ consumers in round-robin bursts.
// Optional PRIORITY0_EN: consumer 0 always wins arbitration and does not move rr_ptr.
//
// state | meaning
// IDLE  | no grant; arbitrate when someone requests and the FIFO has data
// BURST | one consumer granted; pop up to BURST_LEN words for it
module fifo_read_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock_read,
    input  logic                  read_reset,
    input  logic [NUM_REQ-1:0]    request,
    input  logic [NUM_REQ-1:0]    consumer_ready,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_enable,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_W-1:0]       out_id
);

    localparam int         IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_next;
    logic [7:0]         beat_count;
    logic [IDX_W-1:0]   g;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] rr_winner;
    logic [NUM_REQ-1:0] winner;
    logic               pick_any;
    logic               arb_go;
    logic               burst_end;
    logic               rr_update;

    always_comb begin
        g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) g = IDX_W'(i);
        end
    end

`ifdef PRIORITY0_EN
    assign pick_req  = request & ~NUM_REQ'(1);
    assign winner    = request[0] ? NUM_REQ'(1) : rr_winner;
    assign arb_go    = (request[0] | pick_any) & ~empty;
    assign rr_update = (g != '0);
`else
    assign pick_req  = request;
    assign winner    = rr_winner;
    assign arb_go    = pick_any & ~empty;
    assign rr_update = 1'b1;
`endif

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .request (pick_req),
        .rr_ptr  (rr_ptr),
        .winner  (rr_winner),
        .any_req (pick_any)
    );

    assign rr_next   = ID_W'((int'(g) + 1) % NUM_REQ);
    assign burst_end = (read_enable && (beat_count == LAST_BEAT)) || !request[g] || empty;

    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_go)    state_nxt = BURST;
            BURST:   if (burst_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read_enable = 1'b0;
        if (state == BURST && !read_reset)
            read_enable = !empty && request[g] && consumer_ready[g];
    end

    always_ff @(posedge clock_read or posedge read_reset) begin
        if (read_reset) begin
            grant      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            rr_ptr     <= '0;
            beat_count <= '0;
        end else begin
            out_valid <= read_enable;
            if (read_enable) begin
                out_data   <= read_data;
                out_id     <= ID_W'(g);
                beat_count <= beat_count + 8'd1;
            end
            case (state)
                IDLE: begin
                    if (arb_go) begin
                        grant      <= winner;
                        beat_count <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        grant <= '0;
                        if (rr_update) rr_ptr <= rr_next;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Randomized and directed bench for fifo_read_arbiter against a transaction-level model.
module tb_fifo_read_arbiter;

    localparam int NR = 4;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          read_reset;
    logic [NR-1:0] request;
    logic [NR-1:0] consumer_ready;
    logic          empty;
    logic [7:0]    read_data;
    logic          read_enable;
    logic [NR-1:0] grant;
    logic          out_valid;
    logic [7:0]    out_data;
    logic [2:0]    out_id;

    fifo_read_arbiter #(
        .NUM_REQ    (NR),
        .BURST_LEN  (BL),
        .DATA_WIDTH (8)
    ) dut (
        .clock_read     (clk),
        .read_reset     (read_reset),
        .request        (request),
        .consumer_ready (consumer_ready),
        .empty          (empty),
        .read_data      (read_data),
        .read_enable    (read_enable),
        .grant          (grant),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_id         (out_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents, current owner (-1 = none), words given, round-robin start.
    logic [7:0] q[$];
    int         owner;
    int         beats;
    int         rr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_id;
    logic [3:0] exp_grant;
    logic [2:0] dut_ids[$];
    logic [7:0] dut_data[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner     = -1;
        beats     = 0;
        rr        = 0;
        exp_valid = 1'b0;
        exp_data  = '0;
        exp_id    = '0;
        exp_grant = '0;
        q.delete();
    endtask

    task automatic model_pick(input logic [3:0] req, output int w);
        w = -1;
`ifdef PRIORITY0_EN
        if (req[0]) begin
            w = 0;
            return;
        end
`endif
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (rr + k) % NR;
`ifdef PRIORITY0_EN
            if (idx == 0) continue;
`endif
            if (w < 0 && req[idx]) w = idx;
        end
    endtask

    task automatic push_words(input int n, input bit counting, input int base);
        for (int k = 0; k < n; k++) q.push_back(counting ? 8'(base + k) : 8'($urandom));
    endtask

    task automatic cycle(input logic [3:0] req, input logic [3:0] rdy);
        logic exp_re;
        int   w;
        @(negedge clk);
        request        = req;
        consumer_ready = rdy;
        empty          = (q.size() == 0);
        read_data      = empty ? 8'($urandom) : q[0];
        #1;
        exp_re = (owner >= 0) ? (!empty && req[owner] && rdy[owner]) : 1'b0;
        check_eq("read_enable", 32'(read_enable), 32'(exp_re));
        @(posedge clk);
        if (owner < 0) begin
            exp_valid = 1'b0;
            if (req != 0 && !empty) begin
                model_pick(req, w);
                owner     = w;
                beats     = 0;
                exp_grant = 4'(1 << w);
            end
        end else begin
            if (exp_re) begin
                exp_valid = 1'b1;
                exp_data  = q.pop_front();
                exp_id    = 3'(owner);
                beats++;
            end else begin
                exp_valid = 1'b0;
            end
            if ((exp_re && beats == BL) || !req[owner] || empty) begin
`ifdef PRIORITY0_EN
                if (owner != 0) rr = (owner + 1) % NR;
`else
                rr = (owner + 1) % NR;
`endif
                owner     = -1;
                exp_grant = '0;
            end
        end
        #1;
        check_eq("grant", 32'(grant), 32'(exp_grant));
        check_eq("out_valid", 32'(out_valid), 32'(exp_valid));
        check_eq("out_data", 32'(out_data), 32'(exp_data));
        check_eq("out_id", 32'(out_id), 32'(exp_id));
        if (out_valid === 1'b1) begin
            dut_ids.push_back(out_id);
            dut_data.push_back(out_data);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        read_reset     = 1'b1;
        request        = '0;
        consumer_ready = '0;
        empty          = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_data", 32'(out_data), 32'h0);
        check_eq("rst_out_id", 32'(out_id), 32'h0);
        check_eq("rst_read_enable", 32'(read_enable), 32'h0);
        @(negedge clk);
        read_reset = 1'b0;
        dut_ids.delete();
        dut_data.delete();
    endtask

    initial begin
        logic [3:0] req;
        int         guard;
        read_reset     = 1'b1;
        request        = '0;
        consumer_ready = '0;
        empty          = 1'b1;
        read_data      = '0;
        model_reset();

        // Single requester, three words.
        do_reset();
        push_words(3, 1'b1, 8'hA0);
        repeat (8) cycle(4'b0001, 4'b1111);
        check_eq("single_count", 32'(dut_ids.size()), 32'd3);
        for (int k = 0; k < dut_data.size() && k < 3; k++)
            check_eq("single_data", 32'(dut_data[k]), 32'(8'hA0 + k));

        // Fairness: 40 words, everybody requesting.
        do_reset();
        push_words(40, 1'b1, 0);
        repeat (52) cycle(4'b1111, 4'b1111);
        check_eq("fair_count", 32'(dut_ids.size()), 32'd40);
        for (int k = 0; k < dut_ids.size(); k += BL)
            check_eq("fair_burst_id", 32'(dut_ids[k]), 32'((k / BL) % NR));
        for (int k = 0; k < dut_data.size(); k++)
            if (dut_data[k] !== 8'(k)) check_eq("fair_order", 32'(dut_data[k]), 32'(k));

        // Backpressure on consumer 2 mid-burst.
        do_reset();
        push_words(12, 1'b1, 8'h40);
        for (int c = 0; c < 24; c++)
            cycle(4'b0100, (c >= 3 && c <= 5) ? 4'b1011 : 4'b1111);
        check_eq("bp_count", 32'(dut_ids.size()), 32'd12);

        // Consumer 1 withdraws after two words; consumer 2 next.
        do_reset();
        push_words(10, 1'b1, 8'h60);
        repeat (3) cycle(4'b0110, 4'b1111);
        repeat (14) cycle(4'b0100, 4'b1111);
        check_eq("wd_count", 32'(dut_ids.size()), 32'd10);
        if (dut_ids.size() >= 3) begin
            check_eq("wd_id_second", 32'(dut_ids[1]), 32'd1);
            check_eq("wd_id_third", 32'(dut_ids[2]), 32'd2);
        end

        // Empty and last beat together for consumer 3, then rr wraps to 0.
        do_reset();
        push_words(8, 1'b1, 8'h80);
        repeat (12) cycle(4'b1000, 4'b1111);
        check_eq("co_count", 32'(dut_ids.size()), 32'd8);
        push_words(2, 1'b1, 8'h90);
        repeat (5) cycle(4'b1111, 4'b1111);
        if (dut_ids.size() >= 9) check_eq("co_next_id", 32'(dut_ids[8]), 32'd0);
        else check_eq("co_next_count", 32'(dut_ids.size()), 32'd9);

        // Reset in the middle of a burst.
        do_reset();
        push_words(20, 1'b0, 0);
        guard = 0;
        while (dut_ids.size() < 3 && guard < 20) begin
            cycle(4'b1111, 4'b1111);
            guard++;
        end
        check_eq("mid_reach_word3", 32'(dut_ids.size()), 32'd3);
        @(negedge clk);
        request        = 4'b1111;
        consumer_ready = 4'b1111;
        empty          = (q.size() == 0);
        read_data      = empty ? 8'h00 : q[0];
        #1;
        check_eq("mid_re_before", 32'(read_enable), 32'd1);
        read_reset = 1'b1;
        #1;
        check_eq("mid_rst_grant", 32'(grant), 32'h0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
        check_eq("mid_rst_re", 32'(read_enable), 32'h0);
        @(negedge clk);
        model_reset();
        empty      = 1'b1;
        read_reset = 1'b0;
        dut_ids.delete();
        cycle(4'b1110, 4'b1111);
        push_words(4, 1'b0, 0);
        repeat (8) cycle(4'b1111, 4'b1111);
        if (dut_ids.size() > 0) check_eq("mid_restart_id", 32'(dut_ids[0]), 32'd0);
        else check_eq("mid_restart_count", 32'(dut_ids.size()), 32'd4);

        // Random traffic.
        do_reset();
        req = 4'($urandom);
        for (int c = 0; c < 1500; c++) begin
            logic [3:0] rdy;
            if ($urandom_range(7) == 0) req = 4'($urandom);
            for (int b = 0; b < NR; b++) rdy[b] = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0 && q.size() < 60) push_words($urandom_range(1, 3), 1'b0, 0);
            cycle(req, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
